// File: rtl/psum_writeback_pkg.sv
// Shared PE control types for the psum write-back path: psum modes, the
// pad-write record, half-write masks and the pack/hold FSM states.
package psum_writeback_pkg;

    localparam int P_DWD     = 8;
    localparam int P_PSUMDWD = 16;
    localparam int P_PEROW   = 3;
    localparam int P_ADDRWD  = 5;

    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;
    localparam logic [1:0] MASK_FULL = 2'b11;

    // Encodings match the fetch path: 1 selects the packed D16 layout.
    typedef enum logic {
        PSUM_FULL = 1'b0,
        PSUM_D16  = 1'b1
    } psum_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [P_ADDRWD-1:0]                waddr;
        logic [P_PEROW-1:0][P_PSUMDWD-1:0]  wdata;
        logic [1:0]                         wmask;
    } ppwr_t;

    // Inverse of the fetch-side split: upper half is what word>>DWD returns.
    function automatic logic [P_PSUMDWD-1:0] pack_halves(input logic [P_DWD-1:0] hi,
                                                         input logic [P_DWD-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/psum_writeback_if.sv
// Handshake buses around the write-back block: the SS-stage beat channel
// and the psum pad write port.
interface psum_ss_if #(
    parameter int PEROW   = psum_writeback_pkg::P_PEROW,
    parameter int PSUMDWD = psum_writeback_pkg::P_PSUMDWD,
    parameter int ADDRWD  = psum_writeback_pkg::P_ADDRWD
);
    logic                           rdy;
    logic                           ack;
    logic [PEROW-1:0][PSUMDWD-1:0]  psum;
    logic [ADDRWD-1:0]              addr;
    logic                           psum_mode;
    logic                           psum_parity;
    logic                           last;

    modport master (output rdy, psum, addr, psum_mode, psum_parity, last, input ack);
    modport slave  (input rdy, psum, addr, psum_mode, psum_parity, last, output ack);
endinterface

interface psum_pp_if #(
    parameter int PEROW   = psum_writeback_pkg::P_PEROW,
    parameter int PSUMDWD = psum_writeback_pkg::P_PSUMDWD,
    parameter int ADDRWD  = psum_writeback_pkg::P_ADDRWD
);
    logic                           rdy;
    logic                           ack;
    logic [ADDRWD-1:0]              waddr;
    logic [PEROW-1:0][PSUMDWD-1:0]  wdata;
    logic [1:0]                     wmask;

    modport master (output rdy, waddr, wdata, wmask, input ack);
    modport slave  (input rdy, waddr, wdata, wmask, output ack);
endinterface

// File: rtl/psum_writeback_pack_hold.sv
// Hold register for the parity-0 lower halves: keeps the halves and their
// address, compares the incoming address and forms flush / merged words.
module psum_pack_hold #(
    parameter int DWD     = psum_writeback_pkg::P_DWD,
    parameter int PSUMDWD = psum_writeback_pkg::P_PSUMDWD,
    parameter int PEROW   = psum_writeback_pkg::P_PEROW,
    parameter int ADDRWD  = psum_writeback_pkg::P_ADDRWD
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           capture,
    input  logic [PEROW-1:0][PSUMDWD-1:0]  psum,
    input  logic [ADDRWD-1:0]              addr,
    output logic [ADDRWD-1:0]              held_addr,
    output logic                           addr_match,
    output logic [PEROW-1:0][PSUMDWD-1:0]  flush_data,
    output logic [PEROW-1:0][PSUMDWD-1:0]  merge_data
);
    import psum_writeback_pkg::*;

    logic [PEROW-1:0][DWD-1:0] held_low_r;
    logic [ADDRWD-1:0]         held_addr_r;

    // Capture the truncated lower halves and their pad address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_low_r  <= '0;
            held_addr_r <= '0;
        end else if (capture) begin
            for (int r = 0; r < PEROW; r++) begin
                held_low_r[r] <= psum[r][DWD-1:0];
            end
            held_addr_r <= addr;
        end else begin
            held_low_r  <= held_low_r;
            held_addr_r <= held_addr_r;
        end
    end

    // Flush word carries only the held half; merge word pairs it with the new upper half
    always_comb begin
        flush_data = '0;
        merge_data = '0;
        for (int r = 0; r < PEROW; r++) begin
            flush_data[r] = pack_halves({DWD{1'b0}}, held_low_r[r]);
            merge_data[r] = pack_halves(psum[r][DWD-1:0], held_low_r[r]);
        end
    end

    assign held_addr  = held_addr_r;
    assign addr_match = (held_addr_r == addr);

endmodule

// File: rtl/psum_writeback.sv
// Psum write-back: packs per-row partial sums (full width or D16 halves)
// into pad writes with per-half masks, behind rdy/ack on both sides.
module psum_writeback #(
    parameter int DWD     = psum_writeback_pkg::P_DWD,
    parameter int PSUMDWD = psum_writeback_pkg::P_PSUMDWD,
    parameter int PEROW   = psum_writeback_pkg::P_PEROW,
    parameter int ADDRWD  = psum_writeback_pkg::P_ADDRWD
) (
    input  logic              i_clk,
    input  logic              i_rst,
    psum_ss_if.slave          ss,
    psum_pp_if.master         pp,
    output logic [15:0]       o_wcnt,
    output logic              o_err
);
    import psum_writeback_pkg::*;

    wb_state_e  state_r;
    ppwr_t      out_r;
    logic       pp_rdy_r;
    logic       err_r;
    logic [15:0] wcnt_r;

    logic [ADDRWD-1:0]             held_addr_s;
    logic                          addr_match_s;
    logic [PEROW-1:0][PSUMDWD-1:0] flush_data_s;
    logic [PEROW-1:0][PSUMDWD-1:0] merge_data_s;
    logic [PEROW-1:0][PSUMDWD-1:0] lo_data_s;
    logic [PEROW-1:0][PSUMDWD-1:0] hi_data_s;

    logic       free_s;
    logic       d16_s;
    logic       pair_s;
    logic       flush_req_s;
    logic       ack_s;
    logic       take_s;
    logic       load_s;
    logic       capture_s;
    logic       err_set_s;
    ppwr_t      load_data_s;
    wb_state_e  state_nxt_s;

    psum_pack_hold #(
        .DWD     (DWD),
        .PSUMDWD (PSUMDWD),
        .PEROW   (PEROW),
        .ADDRWD  (ADDRWD)
    ) u_hold (
        .clk        (i_clk),
        .rst_n      (i_rst),
        .capture    (capture_s),
        .psum       (ss.psum),
        .addr       (ss.addr),
        .held_addr  (held_addr_s),
        .addr_match (addr_match_s),
        .flush_data (flush_data_s),
        .merge_data (merge_data_s)
    );

    // Single-half words for a lone lower half or an orphan upper half
    always_comb begin
        lo_data_s = '0;
        hi_data_s = '0;
        for (int r = 0; r < PEROW; r++) begin
            lo_data_s[r] = pack_halves({DWD{1'b0}}, ss.psum[r][DWD-1:0]);
            hi_data_s[r] = pack_halves(ss.psum[r][DWD-1:0], {DWD{1'b0}});
        end
    end

    // Beat decode: a held half must be flushed before anything but its matching upper half
    always_comb begin
        free_s      = !pp_rdy_r || pp.ack;
        d16_s       = (ss.psum_mode == PSUM_D16);
        pair_s      = d16_s && ss.psum_parity && addr_match_s;
        flush_req_s = (state_r == HELD) && ss.rdy && !pair_s;
        ack_s       = free_s && !flush_req_s;
        take_s      = ss.rdy && ack_s;
        load_s      = 1'b0;
        capture_s   = 1'b0;
        err_set_s   = 1'b0;
        load_data_s = '0;
        state_nxt_s = state_r;
        if (free_s && flush_req_s) begin
            load_s            = 1'b1;
            load_data_s.waddr = held_addr_s;
            load_data_s.wdata = flush_data_s;
            load_data_s.wmask = MASK_LO;
            err_set_s         = d16_s;
            state_nxt_s       = IDLE;
        end else if (take_s) begin
            if (!d16_s) begin
                load_s            = 1'b1;
                load_data_s.waddr = ss.addr;
                load_data_s.wdata = ss.psum;
                load_data_s.wmask = MASK_FULL;
            end else if (!ss.psum_parity) begin
                if (ss.last) begin
                    load_s            = 1'b1;
                    load_data_s.waddr = ss.addr;
                    load_data_s.wdata = lo_data_s;
                    load_data_s.wmask = MASK_LO;
                end else begin
                    capture_s   = 1'b1;
                    state_nxt_s = HELD;
                end
            end else if (state_r == HELD) begin
                load_s            = 1'b1;
                load_data_s.waddr = held_addr_s;
                load_data_s.wdata = merge_data_s;
                load_data_s.wmask = MASK_FULL;
                state_nxt_s       = IDLE;
            end else begin
                load_s            = 1'b1;
                load_data_s.waddr = ss.addr;
                load_data_s.wdata = hi_data_s;
                load_data_s.wmask = MASK_HI;
                err_set_s         = 1'b1;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // FSM state, pending-write register, sticky error and write counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r  <= IDLE;
            out_r    <= '0;
            pp_rdy_r <= 1'b0;
            err_r    <= 1'b0;
            wcnt_r   <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                out_r    <= load_data_s;
                pp_rdy_r <= 1'b1;
            end else if (pp.ack) begin
                pp_rdy_r <= 1'b0;
            end else begin
                pp_rdy_r <= pp_rdy_r;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (pp_rdy_r && pp.ack && (wcnt_r != 16'hffff)) begin
                wcnt_r <= wcnt_r + 16'd1;
            end else begin
                wcnt_r <= wcnt_r;
            end
        end
    end

    assign ss.ack   = ack_s;
    assign pp.rdy   = pp_rdy_r;
    assign pp.waddr = out_r.waddr;
    assign pp.wdata = out_r.wdata;
    assign pp.wmask = out_r.wmask;
    assign o_wcnt   = wcnt_r;
    assign o_err    = err_r;

endmodule

// File: tb/tb_psum_writeback.sv
// Scoreboard bench for psum_writeback: stimulus queues expected pad writes,
// a monitor pops and compares each accepted write.
module tb_psum_writeback;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] wcnt;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  waddr;
        logic [47:0] wdata;
        logic [1:0]  wmask;
    } exp_t;

    exp_t exp_q[$];

    psum_ss_if ss_bus ();
    psum_pp_if pp_bus ();

    psum_writeback dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .ss     (ss_bus),
        .pp     (pp_bus),
        .o_wcnt (wcnt),
        .o_err  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] rows(input logic [15:0] p0, input logic [15:0] p1,
                                         input logic [15:0] p2);
        return {p2, p1, p0};
    endfunction

    task automatic expect_write(input logic [4:0] a, input logic [47:0] d, input logic [1:0] m);
        exp_t e;
        e.waddr = a;
        e.wdata = d;
        e.wmask = m;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; reports stalled cycles.
    task automatic beat(input logic mode, input logic par, input logic last,
                        input logic [4:0] addr, input logic [47:0] data, output int stalls);
        stalls             = 0;
        ss_bus.rdy         = 1'b1;
        ss_bus.psum_mode   = mode;
        ss_bus.psum_parity = par;
        ss_bus.last        = last;
        ss_bus.addr        = addr;
        ss_bus.psum        = data;
        @(negedge clk);
        while (!ss_bus.ack && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (!ss_bus.ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: ack=0, expected 1");
        end
        @(posedge clk);
        #1;
        ss_bus.rdy = 1'b0;
    endtask

    // Monitor: every accepted pad write must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pp_bus.rdy && pp_bus.ack) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h mask %0h, expected none",
                             pp_bus.waddr, pp_bus.wdata, pp_bus.wmask);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", 64'(pp_bus.waddr), 64'(e.waddr));
                    check("wdata", 64'(pp_bus.wdata), 64'(e.wdata));
                    check("wmask", 64'(pp_bus.wmask), 64'(e.wmask));
                end
            end
        end
    end

    initial begin
        int st;
        int guard;
        ss_bus.rdy         = 1'b0;
        ss_bus.psum_mode   = 1'b0;
        ss_bus.psum_parity = 1'b0;
        ss_bus.last        = 1'b0;
        ss_bus.addr        = 5'd0;
        ss_bus.psum        = 48'd0;
        pp_bus.ack         = 1'b1;

        #12;
        check("rst_pp_rdy", 64'(pp_bus.rdy), 64'd0);
        check("rst_waddr",  64'(pp_bus.waddr), 64'd0);
        check("rst_wdata",  64'(pp_bus.wdata), 64'd0);
        check("rst_wmask",  64'(pp_bus.wmask), 64'd0);
        check("rst_wcnt",   64'(wcnt), 64'd0);
        check("rst_err",    64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);

        // Full-width beat
        expect_write(5'd3, rows(16'h1234, 16'h0042, 16'hffff), 2'b11);
        beat(1'b0, 1'b0, 1'b0, 5'd3, rows(16'h1234, 16'h0042, 16'hffff), st);
        check("full_stall", 64'(st), 64'd0);
        check("full_rdy_next", 64'(pp_bus.rdy), 64'd1);
        cycles(1);
        check("full_wcnt", 64'(wcnt), 64'd1);
        check("full_err", 64'(err), 64'd0);

        // D16 pair at the same address, upper bytes of the inputs must be dropped
        expect_write(5'd5, rows(16'hbbaa, 16'hbcab, 16'hbdac), 2'b11);
        beat(1'b1, 1'b0, 1'b0, 5'd5, rows(16'h11aa, 16'h22ab, 16'h33ac), st);
        check("pair_p0_stall", 64'(st), 64'd0);
        check("pair_no_write", 64'(pp_bus.rdy), 64'd0);
        beat(1'b1, 1'b1, 1'b0, 5'd5, rows(16'h44bb, 16'h55bc, 16'h66bd), st);
        check("pair_p1_stall", 64'(st), 64'd0);
        cycles(2);
        check("pair_err", 64'(err), 64'd0);
        check("pair_wcnt", 64'(wcnt), 64'd2);

        // D16 address mismatch: flush, then orphan upper half
        expect_write(5'd5, rows(16'h00aa, 16'h00aa, 16'h00aa), 2'b01);
        expect_write(5'd6, rows(16'hbb00, 16'hbb00, 16'hbb00), 2'b10);
        beat(1'b1, 1'b0, 1'b0, 5'd5, rows(16'h00aa, 16'h00aa, 16'h00aa), st);
        beat(1'b1, 1'b1, 1'b0, 5'd6, rows(16'h00bb, 16'h00bb, 16'h00bb), st);
        check("mismatch_stall", 64'(st), 64'd1);
        cycles(2);
        check("mismatch_err", 64'(err), 64'd1);

        // Lone lower half on last beat, then FSM must be IDLE (next upper half is orphan)
        expect_write(5'd2, rows(16'h0077, 16'h0077, 16'h0077), 2'b01);
        expect_write(5'd2, rows(16'h9900, 16'h9900, 16'h9900), 2'b10);
        beat(1'b1, 1'b0, 1'b1, 5'd2, rows(16'h0077, 16'h0077, 16'h0077), st);
        check("last_stall", 64'(st), 64'd0);
        beat(1'b1, 1'b1, 1'b0, 5'd2, rows(16'h0099, 16'h0099, 16'h0099), st);
        cycles(2);
        check("last_wcnt", 64'(wcnt), 64'd6);

        // Backpressure: pending write must hold steady and block the next beat
        pp_bus.ack = 1'b0;
        expect_write(5'd7, rows(16'h0a0a, 16'h0b0b, 16'h0c0c), 2'b11);
        expect_write(5'd8, rows(16'h1d1d, 16'h1e1e, 16'h1f1f), 2'b11);
        beat(1'b0, 1'b0, 1'b0, 5'd7, rows(16'h0a0a, 16'h0b0b, 16'h0c0c), st);
        ss_bus.rdy  = 1'b1;
        ss_bus.addr = 5'd8;
        ss_bus.psum = rows(16'h1d1d, 16'h1e1e, 16'h1f1f);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ss_ack", 64'(ss_bus.ack), 64'd0);
            check("bp_pp_rdy", 64'(pp_bus.rdy), 64'd1);
            check("bp_waddr", 64'(pp_bus.waddr), 64'd7);
            check("bp_wdata", 64'(pp_bus.wdata), 64'(rows(16'h0a0a, 16'h0b0b, 16'h0c0c)));
        end
        @(posedge clk);
        #1;
        pp_bus.ack = 1'b1;
        @(negedge clk);
        check("bp_release_ack", 64'(ss_bus.ack), 64'd1);
        @(posedge clk);
        #1;
        ss_bus.rdy = 1'b0;
        cycles(2);
        check("bp_wcnt", 64'(wcnt), 64'd8);

        // Reset with a write pending drops it; reset in HELD drops the held half
        pp_bus.ack = 1'b0;
        beat(1'b0, 1'b0, 1'b0, 5'd9, rows(16'h5555, 16'h6666, 16'h7777), st);
        check("pend_rdy", 64'(pp_bus.rdy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy",   64'(pp_bus.rdy), 64'd0);
        check("mid_rst_waddr", 64'(pp_bus.waddr), 64'd0);
        check("mid_rst_wdata", 64'(pp_bus.wdata), 64'd0);
        check("mid_rst_wmask", 64'(pp_bus.wmask), 64'd0);
        check("mid_rst_wcnt",  64'(wcnt), 64'd0);
        check("mid_rst_err",   64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        pp_bus.ack = 1'b1;
        beat(1'b1, 1'b0, 1'b0, 5'd10, rows(16'h0011, 16'h0022, 16'h0033), st);
        #2;
        rst_n = 1'b0;
        #1;
        check("held_rst_rdy", 64'(pp_bus.rdy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_write(5'd10, rows(16'h5500, 16'h6600, 16'h7700), 2'b10);
        beat(1'b1, 1'b1, 1'b0, 5'd10, rows(16'h1255, 16'h3466, 16'h5677), st);
        check("orphan_stall", 64'(st), 64'd0);
        cycles(2);
        check("orphan_err", 64'(err), 64'd1);
        check("orphan_wcnt", 64'(wcnt), 64'd1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            guard++;
            cycles(1);
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Write-side counterpart of the PE fetch path. Takes per-row partial sums from the last PE pipeline stage and writes them back into the psum pad.
- Two modes:
  - full-width mode: one psum per pad word.
  - D16 packed mode: two DWD-wide psums share one PSUMDWD word, and parity selects the half.
- The fetch path reads the upper half as word>>DWD when parity=1. This block is the exact inverse: it merges the parity-0 and parity-1 halves and emits per-half write masks.
- Sits between the SS stage (rdy/ack in) and the psum pad write port (rdy/ack out).

Parameters:
- DWD, 8, single-operand data width and packed half width.
- PSUMDWD, 16, psum word width; must equal 2*DWD.
- PEROW, 3, number of PE rows written in parallel.
- ADDRWD, 5, psum pad address width.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous active-low reset.
- i_SS_rdy  input  1  upstream beat valid.
- o_SS_ack  output  1  beat accepted; transfer happens when i_SS_rdy && o_SS_ack.
- i_psum  input  PEROW x PSUMDWD  per-row result.
- i_addr  input  ADDRWD  target pad word.
- i_psum_mode  input  1  1 = D16 packed, 0 = full width.
- i_psum_parity  input  1  half select in D16 mode.
- i_last  input  1  final beat of a tile; forces flush.
- o_PP_rdy  output  1  pad write valid.
- i_PP_ack  input  1  pad accepted the write.
- o_PP_waddr  output  ADDRWD  write address.
- o_PP_wdata  output  PEROW x PSUMDWD  write data.
- o_PP_wmask  output  2  per-half enable; [0] = bits DWD-1:0, [1] = upper half.
- o_wcnt  output  16  completed pad writes, saturating.
- o_err  output  1  sticky parity-sequence error.

Behaviour:
- Reset (i_rst=0, async):
  - o_PP_rdy=0, o_PP_waddr=0, o_PP_wdata=0, o_PP_wmask=0.
  - o_wcnt=0, o_err=0, FSM=IDLE, hold register cleared.
  - Reset mid-operation drops both the held half and any pending write.
- Output register and handshake:
  - The output register holds one pending write and is "free" when !o_PP_rdy || i_PP_ack.
  - o_PP_rdy stays high, with data stable, until i_PP_ack.
  - o_wcnt increments on each o_PP_rdy && i_PP_ack and saturates at 16'hffff.
- FSM states: IDLE (no held half) and HELD (lower halves plus address held in the hold register).
- Full mode, any state:
  - IDLE: a beat loads the output register {waddr=i_addr, wdata=i_psum, wmask=11}.
  - HELD: first flush the held half (see Flush), stalling the input for that cycle; the full beat is accepted next cycle.
- D16, parity=0:
  - IDLE: capture i_psum[r][DWD-1:0] and the address into the hold register and go to HELD; no write is issued.
  - IDLE with i_last=1: write {0, low} with mask 01 immediately and stay in IDLE.
  - HELD: flush the held half, set o_err, then treat the beat as a fresh IDLE beat on the following cycle.
- D16, parity=1:
  - HELD with matching address: write {i_psum[r][DWD-1:0], held_low} with mask 11, go to IDLE. Single cycle, no stall.
  - HELD with address mismatch: flush the held half (mask 01) with o_SS_ack=0 for that cycle, set o_err, go to IDLE. Next cycle, the beat is processed as an orphan.
  - IDLE (orphan): write {i_psum[r][DWD-1:0], 0} with mask 10 and set o_err.
- Flush: load the output register with {0, held_low}, mask 01, held address; go to IDLE. A flush consumes no input beat.
- i_last=1 on a parity-0 beat in HELD: after the error flush, the new half is written alone (mask 01), not held.
- o_SS_ack = output register free && no flush required this cycle.
- Latency: an accepted full-width or completing beat appears on o_PP_rdy the next cycle. Throughput is 1 write/cycle under continuous i_PP_ack.
- Width rule: packed halves truncate i_psum to its low DWD bits; no saturation.
- Simultaneous drain and load: when i_PP_ack and a new load occur in the same cycle, o_PP_rdy stays 1 and the data updates.

Decomposition:
- Shared PE control package holds:
  - the psum mode enum (D16 / full), reusing the existing values;
  - the PPwr struct {waddr, wdata[PEROW], wmask};
  - localparams MASK_LO=2'b01, MASK_HI=2'b10, MASK_FULL=2'b11;
  - the FSM state enum {IDLE, HELD}.
- One sub-module, psum_pack_hold: the hold register with address compare and flush-data generation.

Test Plan:
- Full mode, addr=3, psum rows {0x1234, 0x0042, 0xffff}, ack held high -> next cycle o_PP_rdy=1, waddr=3, wdata as input, wmask=11, o_wcnt=1.
- D16, parity0 psum 0x00aa @addr5 then parity1 psum 0x00bb @addr5 -> exactly one write: wdata=0xbbaa per row, wmask=11, o_err=0.
- D16, parity0 @addr5 then parity1 @addr6 -> o_SS_ack=0 for one cycle; write addr5 {0x00aa} mask 01; then write addr6 {0xbb00} mask 10; o_err=1.
- D16, parity0 with i_last=1, psum 0x0077 @addr2 -> write mask 01, wdata=0x0077, FSM returns to IDLE.
- Backpressure: i_PP_ack=0 for 4 cycles with a write pending -> o_PP_rdy and data stable, o_SS_ack=0; ack pulse -> both accepted back-to-back with no loss.
- Assert i_rst mid-HELD with a write pending -> all outputs 0 immediately; after release, a parity1 beat is treated as an orphan (mask 10).
